add_sub_x_serial: RTL

//  Parametrised, multi-cycle successor of the combinational ADD/SUB/ADX/SBX unit.

---
 rtl/add_sub_x_serial.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/add_sub_x_serial.sv
// add_sub_x_serial: slice-serial ADD/SUB/ADX/SBX unit owning the EX register.
// An accepted op is processed SLICE bits per cycle over STEPS cycles on two
// carry chains (operand chain cr0, EX chain cr1); the result is then held
// with its flags until the consumer takes it.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a request; operands and EX snapshot latched on accept
// RUN    | one slice per cycle; EX committed on the last slice edge
// DONE   | result and flags held until res_ready
module add_sub_x_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] a,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] q,
  output logic             eq,
  output logic             lt,
  output logic             un,
  output logic [WIDTH-1:0] ex_q,
  input  logic             ex_wr_en,
  input  logic [WIDTH-1:0] ex_wr_data
);

  localparam int STEPS = WIDTH / SLICE;
  localparam int STW   = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_b, r_a, r_x, r_q, r_ex;
  logic             r_cr0, r_cr1;
  logic [STW-1:0]   r_step;
  logic             r_eq, r_lt, r_un;

  logic             w_accept, w_last, w_is_x;
  logic [SLICE:0]   w_s_full, w_t_full;
  logic [SLICE-1:0] w_slice;
  logic             w_c, w_e, w_of;
  logic [WIDTH-1:0] w_q_nxt, w_ex_commit;

  assign w_accept = (r_state == S_IDLE) && op_valid;
  assign w_last   = (r_step == STW'(STEPS - 1));
  assign w_is_x   = r_op[1];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (op_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (res_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    op_ready  = (r_state == S_IDLE);
    res_valid = (r_state == S_DONE);
  end

  // One slice of both carry chains; the operand registers shift right so the
  // current slice is always in the low bits and the MSB slice arrives last.
  always_comb begin
    w_s_full = {1'b0, r_b[SLICE-1:0]} + {1'b0, r_a[SLICE-1:0]} + (SLICE+1)'(r_cr0);
    w_t_full = {1'b0, w_s_full[SLICE-1:0]} + {1'b0, r_x[SLICE-1:0]} + (SLICE+1)'(r_cr1);
    w_slice  = w_is_x ? w_t_full[SLICE-1:0] : w_s_full[SLICE-1:0];
    w_c      = w_s_full[SLICE];
    w_e      = w_is_x ? w_t_full[SLICE] : 1'b0;
    w_q_nxt  = (r_q >> SLICE) | (WIDTH'(w_slice) << (WIDTH - SLICE));
    // On the last slice r_b/r_a hold b[MSB] and a'[MSB] at bit SLICE-1.
    w_of     = (r_b[SLICE-1] == r_a[SLICE-1]) && (r_b[SLICE-1] != w_s_full[SLICE-1]);
  end

  // EX value implied by the final carries of the two chains.
  always_comb begin
    w_ex_commit = '0;
    case (r_op)
      2'b00:   w_ex_commit = WIDTH'(w_c);
      2'b01:   w_ex_commit = w_c ? '0 : '1;
      2'b10:   w_ex_commit = WIDTH'(w_c) + WIDTH'(w_e);
      default: w_ex_commit = WIDTH'(w_c) + WIDTH'(w_e) - WIDTH'(1);
    endcase
  end

  // Operand capture, slice stepping, result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= '0;
      r_b    <= '0;
      r_a    <= '0;
      r_x    <= '0;
      r_q    <= '0;
      r_cr0  <= 1'b0;
      r_cr1  <= 1'b0;
      r_step <= '0;
      r_eq   <= 1'b0;
      r_lt   <= 1'b0;
      r_un   <= 1'b0;
    end else if (w_accept) begin
      r_op   <= op;
      r_b    <= b;
      r_a    <= a ^ {WIDTH{op[0]}};
      r_x    <= r_ex;
      r_cr0  <= op[0];
      r_cr1  <= 1'b0;
      r_step <= '0;
    end else if (r_state == S_RUN) begin
      r_b    <= r_b >> SLICE;
      r_a    <= r_a >> SLICE;
      r_x    <= r_x >> SLICE;
      r_q    <= w_q_nxt;
      r_cr0  <= w_c;
      r_cr1  <= w_e;
      r_step <= r_step + STW'(1);
      if (w_last) begin
        r_eq <= ~|w_q_nxt;
        r_lt <= ~w_c;
        r_un <= w_q_nxt[WIDTH-1] != w_of;
      end
    end
  end

  // EX register: a direct write has priority over the end-of-op commit.
  always_ff @(posedge clk) begin
    if (rst)                             r_ex <= '0;
    else if (ex_wr_en)                   r_ex <= ex_wr_data;
    else if (r_state == S_RUN && w_last) r_ex <= w_ex_commit;
  end

  assign q    = r_q;
  assign eq   = r_eq;
  assign lt   = r_lt;
  assign un   = r_un;
  assign ex_q = r_ex;

endmodule
